// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock, MSB first.
// Optional sticky overflow detection is built when BINARY_BCD_SEQ_OVF_EN is defined.
module binary_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIN_W-1:0]   opnd, opnd_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt, acc_adj;
  logic [ACC_W-1:0]   bcd_nxt;
  logic               done_nxt;
  logic               accept;
  logic               last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == CNT_W'(1));
  assign busy      = (state == SHIFT);

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    opnd_nxt  = opnd;
    acc_nxt   = acc;
    bcd_nxt   = bcd_out;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          opnd_nxt  = bin_in;
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(BIN_W);
        end
      end
      SHIFT: begin
        // The top bit of the corrected accumulator falls off here (result is mod 10^DIGITS).
        acc_nxt  = ACC_W'({acc_adj, opnd[BIN_W-1]});
        opnd_nxt = opnd << 1;
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_nxt   = acc_nxt;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      opnd    <= '0;
      acc     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      opnd    <= opnd_nxt;
      acc     <= acc_nxt;
      bcd_out <= bcd_nxt;
      done    <= done_nxt;
    end
  end

`ifdef BINARY_BCD_SEQ_OVF_EN
  logic ovf_flag;
  logic carry_out;

  assign carry_out = acc_adj[ACC_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        ovf_flag <= 1'b0;
      end else if (state == SHIFT) begin
        ovf_flag <= ovf_flag | carry_out;
      end
      if (last_step) begin
        overflow <= ovf_flag | carry_out;
      end
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = accept ^ last_step;
  assign overflow   = 1'b0 & unused_ctl;
`endif

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Randomized self-checking bench for binary_bcd_seq: three instances (8b/3d, 8b/2d, 7b/3d)
// run in parallel and are compared against a decimal-arithmetic reference model.
module tb_binary_bcd_seq;

`ifdef BINARY_BCD_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic [6:0]  bin7;

  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic        busy7, done7, ovf7;
  logic [11:0] bcd7;

  int n_checks = 0;
  int n_fail   = 0;

  assign bin7 = bin_in[6:0];

  binary_bcd_seq #(.BIN_W(8), .DIGITS(3)) u8 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8));

  binary_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));

  binary_bcd_seq #(.BIN_W(7), .DIGITS(3)) u7 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin7),
    .busy(busy7), .done(done7), .bcd_out(bcd7), .overflow(ovf7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] to_bcd(input longint unsigned v, input int d);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One conversion of v; optional start pulse (ignored by design) at cycle poke.
  task automatic convert(input logic [7:0] v, input int poke);
    logic [11:0] e8, e7;
    logic [7:0]  e2;
    logic        eo2;
    logic [5:0]  st, est;
    e8  = 12'(to_bcd(64'(v), 3));
    e2  = 8'(to_bcd(64'(v), 2));
    e7  = 12'(to_bcd(64'(v % 8'd128), 3));
    eo2 = OVF_ON && (v >= 8'd100);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      st  = {busy8, done8, busy2, done2, busy7, done7};
      est = {k < 8, k == 8, k < 8, k == 8, k < 7, k == 7};
      n_checks++;
      if (st !== est) begin
        n_fail++;
        $display("FAIL handshake v=%0d k=%0d: got %b expected %b", v, k, st, est);
      end
      if (k == 7) begin
        n_checks++;
        if ({bcd7, ovf7} !== {e7, 1'b0}) begin
          n_fail++;
          $display("FAIL result7 v=%0d: got %h/%b expected %h/0", v, bcd7, ovf7, e7);
        end
      end
      if (k == 8) begin
        n_checks++;
        if ({bcd8, ovf8, bcd2, ovf2} !== {e8, 1'b0, e2, eo2}) begin
          n_fail++;
          $display("FAIL result8 v=%0d: got %h/%b %h/%b expected %h/0 %h/%b",
                   v, bcd8, ovf8, bcd2, ovf2, e8, e2, eo2);
        end
      end
      start  = (k == poke);
      bin_in = 8'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 8'd200;
    #1;
    n_checks++;
    if ({busy8, done8, bcd8, ovf8, busy2, done2, bcd2, ovf2, busy7, done7, bcd7, ovf7} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h %h %h expected zeros", bcd8, bcd2, bcd7);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, bcd8, ovf8, busy2, done2, bcd2, ovf2, busy7, done7, bcd7, ovf7} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got busy=%b done=%b bcd=%h expected zeros", busy8, done8, bcd8);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_cover255;
    convert(8'd255, -1);
  endtask

  task automatic test_directed;
    logic [7:0] vals [7];
    vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200, 8'd127};
    foreach (vals[i]) convert(vals[i], -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) convert(8'($urandom), -1);
  endtask

  task automatic test_ignore_start;
    for (int i = 0; i < 10; i++) convert(8'($urandom), int'($urandom_range(1, 5)));
  endtask

  task automatic test_hold;
    logic [11:0] e8;
    logic        ok;
    convert(8'd173, -1);
    e8 = 12'(to_bcd(64'd173, 3));
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bin_in = 8'($urandom);
      @(negedge clk);
      if (bcd8 !== e8 || done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold: got %h done=%b expected %h done=0", bcd8, done8, e8);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [45];
    logic       exp_done;
    logic [11:0] e8;
    logic [7:0]  e2;
    logic        eo2;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 45; n++) begin
      vals[n] = 8'($urandom);
      bin_in  = vals[n];
      @(negedge clk);
      exp_done = (n >= 8) && (n % 9 == 8);
      n_checks++;
      if ({busy8, done8, busy2, done2} !== {!exp_done, exp_done, !exp_done, exp_done}) begin
        n_fail++;
        $display("FAIL b2b_handshake n=%0d: got %b%b expected %b%b", n, busy8, done8, !exp_done, exp_done);
      end
      if (exp_done) begin
        e8  = 12'(to_bcd(64'(vals[n-8]), 3));
        e2  = 8'(to_bcd(64'(vals[n-8]), 2));
        eo2 = OVF_ON && (vals[n-8] >= 8'd100);
        n_checks++;
        if ({bcd8, bcd2, ovf2} !== {e8, e2, eo2}) begin
          n_fail++;
          $display("FAIL b2b_result n=%0d: got %h %h/%b expected %h %h/%b", n, bcd8, bcd2, ovf2, e8, e2, eo2);
        end
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    convert(8'd77, -1);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd123;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, bcd8, ovf8, busy7, done7, bcd7, ovf7} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b bcd=%h expected 0/000", busy8, bcd8);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 || done2 || done7 || busy8 || busy2 || busy7) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got activity=%b expected 0", seen);
    end
    convert(8'd45, -1);
  endtask

  task automatic test_sweep;
    for (int v = 0; v < 128; v++) convert(8'(v), -1);
  endtask

  initial begin
    start  = 1'b0;
    bin_in = '0;
    reset  = 1'b0;
    test_reset;
    test_cover255;
    test_directed;
    test_random;
    test_ignore_start;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
